// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg
//   Shared definitions for the data-memory access controller:
//   - controller state encoding
//   - bus transfer size codes (SIZE_B / SIZE_H / SIZE_W)
//   - MEM-stage operation codes (alucontrolM values for loads and stores)
//   - small decode helpers used by the controller and its lane unit
// ---------------------------------------------------------------------------
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  function automatic logic op_is_load(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Non-memory codes fall into the word bucket; they are never issued.
  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SIZE_B;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SIZE_H;
      default:                          return SIZE_W;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [7:0] op, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if (op_is_load(op) || op_is_store(op)) begin
      case (op_size(op))
        SIZE_H:  r = lo[0];
        SIZE_W:  r = |lo;
        default: r = 1'b0;
      endcase
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  // Forces the low address bits onto the natural boundary of the access.
  function automatic logic [1:0] align_low(input logic [7:0] op, input logic [1:0] lo);
    case (op_size(op))
      SIZE_H:  return {lo[1], 1'b0};
      SIZE_W:  return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_lane  (purely combinational)
//   Byte-lane steering for the data-memory controller.
//   Store side: op + low address -> byte strobes, lane-replicated data, size.
//   Load side : op + low address + raw bus word -> extended load result.
// Ports
//   i_op        in  8   MEM-stage operation code
//   i_addr_lo   in  2   low byte-address bits (already aligned)
//   i_wdata     in  32  raw store value (rt)
//   i_rdata     in  32  raw word returned by the bus
//   o_wstrb     out 4   byte enables (0 for anything but a store)
//   o_wdata     out 32  replicated store data
//   o_size      out 2   transfer size code
//   o_load_data out 32  sign/zero-extended load result
// ---------------------------------------------------------------------------
module dmem_ctrl_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [1:0]  o_size,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store strobes and replicated write data
  always_comb begin
    o_size  = op_size(i_op);
    o_wstrb = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_op)
      EXE_SB_OP: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      EXE_SH_OP: begin
        o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      EXE_SW_OP: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Byte / halfword selection from the returned word
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Load extension
  always_comb begin
    case (i_op)
      EXE_LB_OP:  o_load_data = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: o_load_data = {24'h00_0000, w_byte};
      EXE_LH_OP:  o_load_data = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: o_load_data = {16'h0000, w_half};
      EXE_LW_OP:  o_load_data = i_rdata;
      default:    o_load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//   MEM-stage data-memory access controller. Takes one load/store per
//   instruction, runs the sram-like req/addr_ok/data_ok handshake, freezes the
//   pipeline until the access completes and returns extended load data.
//
// Configuration macro: DMEM_ADDR_EXC_EN
//   defined   : misaligned half/word accesses raise adel/ades in the request
//               cycle and are never issued.
//   undefined : adel/ades tied low, low address bits forced aligned.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   mem_req/op/addr/wdata       access presented by the MEM stage
//   mem_hold                    pipeline frozen by another stall source
//   flush                       exception/eret flush of the MEM stage
//   stall_out                   freeze request to the hazard unit
//   rdata_out / rdata_valid     extended load result
//   adel / ades                 load / store address error
//   data_req/wr/size/addr/wstrb/wdata, data_addr_ok/data_ok/rdata : bus side
// ---------------------------------------------------------------------------
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          mem_req,
  input  logic [7:0]    mem_op,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic          mem_hold,
  input  logic          flush,
  output logic          stall_out,
  output logic [31:0]   rdata_out,
  output logic          rdata_valid,
  output logic          adel,
  output logic          ades,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [31:0]   data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [31:0]   data_rdata
);

  dmem_state_e   r_state;
  dmem_state_e   w_next_state;

  logic [7:0]    r_op;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [1:0]    r_size;
  logic          r_is_load;
  logic          r_is_store;
  logic          r_cancel;
  logic [31:0]   r_rdata;

  logic          w_is_load;
  logic          w_is_store;
  logic          w_is_mem;
  logic          w_addr_err;
  logic          w_accept;
  logic          w_cancel;
  logic          w_bus_done;
  logic [AW-1:0] w_aligned_addr;
  logic [7:0]    w_lane_op;
  logic [1:0]    w_lane_lo;
  logic [3:0]    w_lane_wstrb;
  logic [31:0]   w_lane_wdata;
  logic [1:0]    w_lane_size;
  logic [31:0]   w_lane_load;

  assign w_is_load      = op_is_load(mem_op);
  assign w_is_store     = op_is_store(mem_op);
  assign w_is_mem       = w_is_load | w_is_store;
  assign w_aligned_addr = {mem_addr[AW-1:2], align_low(mem_op, mem_addr[1:0])};

`ifdef DMEM_ADDR_EXC_EN
  assign w_addr_err = (r_state == ST_IDLE) & mem_req & op_misaligned(mem_op, mem_addr[1:0]);
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) & mem_req & ~flush & w_is_mem & ~w_addr_err;

  // A flush arriving in the same cycle as data_ok still cancels the result.
  assign w_cancel = r_cancel | flush;

  assign w_bus_done = ((r_state == ST_REQ) & data_addr_ok & data_data_ok) |
                      ((r_state == ST_WAIT) & data_data_ok);

  // The lane unit sees the incoming access while idle (to build the request)
  // and the latched access afterwards (to extend the returned word).
  assign w_lane_op = (r_state == ST_IDLE) ? mem_op : r_op;
  assign w_lane_lo = (r_state == ST_IDLE) ? w_aligned_addr[1:0] : r_addr[1:0];

  dmem_ctrl_lane u_lane (
    .i_op        (w_lane_op),
    .i_addr_lo   (w_lane_lo),
    .i_wdata     (mem_wdata),
    .i_rdata     (data_rdata),
    .o_wstrb     (w_lane_wstrb),
    .o_wdata     (w_lane_wdata),
    .o_size      (w_lane_size),
    .o_load_data (w_lane_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_REQ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (data_addr_ok && data_data_ok) begin
          w_next_state = w_cancel ? ST_IDLE : ST_DONE;
        end else if (data_addr_ok) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          w_next_state = w_cancel ? ST_IDLE : ST_DONE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Holding in DONE keeps the same instruction from being issued twice.
        if (flush || !mem_hold) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall_out   = 1'b0;
    data_req    = 1'b0;
    rdata_valid = 1'b0;
    adel        = 1'b0;
    ades        = 1'b0;
    if (!resetn) begin
      stall_out = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          stall_out = w_accept;
          adel      = w_addr_err & w_is_load;
          ades      = w_addr_err & w_is_store;
        end
        ST_REQ: begin
          stall_out = 1'b1;
          data_req  = 1'b1;
        end
        ST_WAIT: begin
          stall_out = 1'b1;
        end
        ST_DONE: begin
          rdata_valid = r_is_load;
        end
        default: begin
          stall_out = 1'b0;
        end
      endcase
    end
  end

  // Request fields captured at acceptance; stable until the next access
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op       <= 8'h00;
      r_addr     <= '0;
      r_wdata    <= 32'h0000_0000;
      r_wstrb    <= 4'b0000;
      r_size     <= 2'b00;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
    end else if (w_accept) begin
      r_op       <= mem_op;
      r_addr     <= w_aligned_addr;
      r_wdata    <= w_lane_wdata;
      r_wstrb    <= w_lane_wstrb;
      r_size     <= w_lane_size;
      r_is_load  <= w_is_load;
      r_is_store <= w_is_store;
    end
  end

  // Cancel flag: a flushed access still completes on the bus but is discarded
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cancel <= 1'b0;
    end else if (w_next_state == ST_IDLE) begin
      r_cancel <= 1'b0;
    end else if (flush && ((r_state == ST_REQ) || (r_state == ST_WAIT))) begin
      r_cancel <= 1'b1;
    end
  end

  // Load result capture on completion of a live load
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata <= 32'h0000_0000;
    end else if (w_bus_done && !w_cancel && r_is_load) begin
      r_rdata <= w_lane_load;
    end
  end

  assign rdata_out  = r_rdata;
  assign data_wr    = r_is_store;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wstrb = r_wstrb;
  assign data_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl: directed scenarios followed by random
//   transactions, all compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_ADD = 8'b0010_0001;

  logic        clk;
  logic        resetn;
  logic        mem_req;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_hold;
  logic        flush;
  logic        stall_out;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        adel;
  logic        ades;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_ctrl #(.AW(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_req      (mem_req),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_hold     (mem_hold),
    .flush        (flush),
    .stall_out    (stall_out),
    .rdata_out    (rdata_out),
    .rdata_valid  (rdata_valid),
    .adel         (adel),
    .ades         (ades),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic int m_nbytes(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_align(input logic [7:0] op, input logic [31:0] a);
    return a - (a % m_nbytes(op));
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [7:0] op, input logic [31:0] a);
    int mask;
    if (!m_is_store(op)) return 4'b0000;
    mask = ((1 << m_nbytes(op)) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] wd);
    if (m_nbytes(op) == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (m_nbytes(op) == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'h0000_00FF;
    h = (rd >> (8 * (a % 4))) & 32'h0000_FFFF;
    case (op)
      OP_LB:   return (b >= 32'd128) ? b - 32'd256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete MEM-stage access with a scripted bus response.
  //  a_dly    : REQ cycles before addr_ok
  //  d_dly    : cycles from addr_ok to data_ok (0 = same cycle)
  //  hold     : DONE cycles with mem_hold=1
  //  flush_at : cycle index (0 = first REQ cycle) for a one-cycle flush, -1 none
  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int a_dly, input int d_dly,
                         input int hold, input int flush_at);
    bit ld, st, err, cancelled, fl;
    logic [31:0] eaddr;
    ld = m_is_load(op);
    st = m_is_store(op);
    err = 1'b0;
    eaddr = m_align(op, addr);
`ifdef DMEM_ADDR_EXC_EN
    err = (ld || st) && ((addr % m_nbytes(op)) != 0);
    eaddr = addr;
`endif
    cancelled = 1'b0;
    mem_req = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
    mem_hold = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = rd;
    #1;
    chk("accept_stall", 32'(stall_out), 32'((ld || st) && !err));
    chk("accept_req", 32'(data_req), 32'd0);
    chk("adel", 32'(adel), 32'(ld && err));
    chk("ades", 32'(ades), 32'(st && err));
    if (!(ld || st) || err) begin
      tick;
      mem_req = 1'b0;
      #1;
      chk("ignored_req", 32'(data_req), 32'd0);
      chk("ignored_stall", 32'(stall_out), 32'd0);
      return;
    end
    tick;
    for (int k = 0; k <= a_dly; k++) begin
      data_addr_ok = (k == a_dly);
      data_data_ok = (k == a_dly) && (d_dly == 0);
      flush = (flush_at == k);
      if (flush) begin cancelled = 1'b1; mem_req = 1'b0; end
      #1;
      chk("req_data_req", 32'(data_req), 32'd1);
      chk("req_stall", 32'(stall_out), 32'd1);
      chk("req_addr", data_addr, eaddr);
      chk("req_wr", 32'(data_wr), 32'(st));
      chk("req_size", 32'(data_size), 32'(m_nbytes(op) >> 1));
      chk("req_wstrb", 32'(data_wstrb), 32'(m_wstrb(op, eaddr)));
      if (st) chk("req_wdata", data_wdata, m_wdata(op, wd));
      tick;
      flush = 1'b0;
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    for (int k = 1; k <= d_dly; k++) begin
      data_data_ok = (k == d_dly);
      flush = (flush_at == a_dly + k);
      if (flush) begin cancelled = 1'b1; mem_req = 1'b0; end
      #1;
      chk("wait_data_req", 32'(data_req), 32'd0);
      chk("wait_stall", 32'(stall_out), 32'd1);
      tick;
      flush = 1'b0;
    end
    data_data_ok = 1'b0;
    if (cancelled) begin
      #1;
      chk("cancel_valid", 32'(rdata_valid), 32'd0);
      chk("cancel_stall", 32'(stall_out), 32'd0);
      chk("cancel_req", 32'(data_req), 32'd0);
      tick;
      chk("cancel_no_reissue", 32'(data_req), 32'd0);
      chk("cancel_valid2", 32'(rdata_valid), 32'd0);
      return;
    end
    for (int h = 0; h <= hold; h++) begin
      fl = (h == 0) && (flush_at == a_dly + d_dly + 1);
      mem_hold = (h < hold) || fl;
      flush = fl;
      #1;
      chk("done_stall", 32'(stall_out), 32'd0);
      chk("done_req", 32'(data_req), 32'd0);
      chk("done_valid", 32'(rdata_valid), 32'(ld));
      if (ld) chk("done_rdata", rdata_out, m_load(op, eaddr, rd));
      tick;
      flush = 1'b0;
      if (fl) break;
    end
    mem_req = 1'b0;
    mem_hold = 1'b0;
    #1;
    chk("idle_valid", 32'(rdata_valid), 32'd0);
    chk("idle_stall", 32'(stall_out), 32'd0);
    chk("idle_req", 32'(data_req), 32'd0);
  endtask

  logic [7:0] ops [9];

  initial begin
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD};
    resetn = 1'b0; mem_req = 1'b0; mem_op = 8'h00; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_hold = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    tick; tick; tick;

    // reset state
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_valid", 32'(rdata_valid), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_adel", 32'(adel), 32'd0);
    chk("rst_ades", 32'(ades), 32'd0);
    resetn = 1'b1;
    tick;

    // SB at byte 3: strobe 1000, replicated byte
    run_txn(OP_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1, 0, -1);
    chk("sb_wstrb_const", 32'(data_wstrb), 32'h8);
    chk("sb_wdata_const", data_wdata, 32'hA5A5_A5A5);
    // LH / LHU upper half
    run_txn(OP_LH,  32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1, 0, -1);
    chk("lh_const", rdata_out, 32'hFFFF_8001);
    run_txn(OP_LHU, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1, 0, -1);
    chk("lhu_const", rdata_out, 32'h0000_8001);
    // addr_ok delayed three cycles, then addr_ok+data_ok together
    run_txn(OP_SH, 32'h0000_4006, 32'h1234_BEEF, 32'h0, 3, 0, 0, -1);
    // flush in WAIT
    run_txn(OP_LW, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 1);
    // mem_hold four cycles in DONE
    run_txn(OP_LB, 32'h0000_6001, 32'h0, 32'h0000_F100, 0, 1, 4, -1);
    // flush in REQ, and flush in DONE
    run_txn(OP_SW, 32'h0000_7000, 32'h0BAD_CAFE, 32'h0, 2, 1, 0, 0);
    run_txn(OP_LBU, 32'h0000_7003, 32'h0, 32'h9900_0000, 0, 0, 2, 1);
    // misaligned word: address error or forced alignment
    run_txn(OP_LW, 32'h0000_3002, 32'h0, 32'h1357_9BDF, 0, 1, 0, -1);
    // non-memory op ignored
    run_txn(OP_ADD, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 0, -1);

    // reset mid-transaction
    mem_req = 1'b1; mem_op = OP_SW; mem_addr = 32'h0000_8000; mem_wdata = 32'h1111_2222;
    tick;
    mem_req = 1'b0;
    #1;
    chk("midrst_req_before", 32'(data_req), 32'd1);
    resetn = 1'b0;
    tick;
    chk("midrst_req", 32'(data_req), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    resetn = 1'b1;
    tick;
    chk("midrst_idle", 32'(data_req), 32'd0);

    // random transactions
    for (int i = 0; i < 60; i++) begin
      int a_dly, d_dly, hold, fat;
      logic [7:0] op;
      op    = ops[$urandom_range(0, 8)];
      a_dly = $urandom_range(0, 3);
      d_dly = $urandom_range(0, 3);
      hold  = $urandom_range(0, 2);
      fat   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, a_dly + d_dly + 1) : -1;
      run_txn(op, $urandom, $urandom, $urandom, a_dly, d_dly, hold, fat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
